// File: rtl/myproject_mul_pkg.sv
// Shared encodings and width helpers for the multiplier / rounding datapath.
package myproject_mul_pkg;

  localparam int unsigned SAT_WRAP      = 0;
  localparam int unsigned SAT_CLAMP     = 1;
  localparam int unsigned ROUND_FLOOR   = 0;
  localparam int unsigned ROUND_HALF_UP = 1;

  // Exact product width after extending each operand by one bit.
  function automatic int unsigned prod_width(input int unsigned w0, input int unsigned w1);
    return w0 + w1 + 1;
  endfunction

endpackage

// File: rtl/myproject_mul_rndsat.sv
// Combinational round-half-up / arithmetic shift / saturate-or-wrap narrowing with overflow flag.
module myproject_mul_rndsat
  import myproject_mul_pkg::*;
#(
  parameter int unsigned P          = 19,
  parameter int unsigned SHIFT      = 0,
  parameter int unsigned ROUND      = ROUND_FLOOR,
  parameter int unsigned SAT        = SAT_CLAMP,
  parameter int unsigned DOUT_W     = 18,
  parameter int unsigned OUT_SIGNED = 1
) (
  input  logic signed [P-1:0]      prod,
  output logic        [DOUT_W-1:0] dout_c,
  output logic                     ovf_c
);

  // One guard bit keeps the rounding add exact.
  localparam int unsigned RW      = P + 1;
  // Compare width: wide enough for both the shifted value and the unsigned output bound.
  localparam int unsigned EW      = ((RW > DOUT_W + 1) ? RW : DOUT_W + 1) + 1;
  localparam int unsigned BIAS_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic signed [RW-1:0] RND_BIAS =
    (ROUND == ROUND_HALF_UP && SHIFT > 0) ? (RW'(1) <<< BIAS_SH) : RW'(0);
  localparam logic signed [EW-1:0] ONE   = EW'(1);
  localparam logic signed [EW-1:0] MAX_V =
    (OUT_SIGNED != 0) ? ((ONE <<< (DOUT_W - 1)) - ONE) : ((ONE <<< DOUT_W) - ONE);
  localparam logic signed [EW-1:0] MIN_V =
    (OUT_SIGNED != 0) ? -(ONE <<< (DOUT_W - 1)) : EW'(0);

  logic signed [RW-1:0] rnd_sum;
  logic signed [RW-1:0] shifted;
  logic signed [EW-1:0] val;

  // Round, shift, range-check, then clamp or keep the low bits.
  always_comb begin
    rnd_sum = RW'(prod) + RND_BIAS;
    shifted = rnd_sum >>> SHIFT;
    val     = EW'(shifted);
    ovf_c   = (val > MAX_V) || (val < MIN_V);
    dout_c  = DOUT_W'(val);
    if (SAT == SAT_CLAMP && ovf_c) begin
      dout_c = (val > MAX_V) ? DOUT_W'(MAX_V) : DOUT_W'(MIN_V);
    end
  end

endmodule

// File: rtl/myproject_mul_pipe_rs.sv
// Pipelined multiplier with valid tracking, rounding-shift, narrowing and overflow flags.
module myproject_mul_pipe_rs
  import myproject_mul_pkg::*;
#(
  parameter int unsigned ID          = 1,
  parameter int unsigned NUM_STAGE   = 2,
  parameter int unsigned din0_WIDTH  = 11,
  parameter int unsigned din1_WIDTH  = 7,
  parameter int unsigned dout_WIDTH  = 18,
  parameter int unsigned DIN0_SIGNED = 1,
  parameter int unsigned DIN1_SIGNED = 1,
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned ROUND       = ROUND_FLOOR,
  parameter int unsigned SAT         = SAT_CLAMP
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_valid,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  clr_sticky,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  ovf,
  output logic                  ovf_sticky
);

  localparam int unsigned P          = prod_width(din0_WIDTH, din1_WIDTH);
  localparam int unsigned D          = NUM_STAGE - 1;
  localparam int unsigned OUT_SIGNED = ((DIN0_SIGNED != 0) || (DIN1_SIGNED != 0)) ? 1 : 0;

  if (NUM_STAGE < 1) begin : g_bad_depth
    $error("myproject_mul_pipe_rs ID %0d: NUM_STAGE must be >= 1", ID);
  end

  logic signed [din0_WIDTH:0] a_ext;
  logic signed [din1_WIDTH:0] b_ext;
  logic signed [P-1:0]        prod;
  logic signed [P-1:0]        prod_d;
  logic                       valid_d;
  logic [dout_WIDTH-1:0]      rs_dout;
  logic                       rs_ovf;

  // Extend each operand by one bit so a single signed multiply covers every signedness mix.
  always_comb begin
    a_ext = (DIN0_SIGNED != 0) ? {din0[din0_WIDTH-1], din0} : {1'b0, din0};
    b_ext = (DIN1_SIGNED != 0) ? {din1[din1_WIDTH-1], din1} : {1'b0, din1};
    prod  = P'(a_ext) * P'(b_ext);
  end

  if (D == 0) begin : g_comb
    assign prod_d  = prod;
    assign valid_d = din_valid;
  end else begin : g_pipe
    logic signed [P-1:0] dly [D];
    logic [D-1:0]        vld;

    // Product register followed by pure delay stages; data needs no reset.
    always_ff @(posedge clk) begin
      if (ce) begin
        dly[0] <= prod;
        for (int i = 1; i < int'(D); i++) dly[i] <= dly[i-1];
      end
    end

    // Valid shift register mirroring the data stages.
    always_ff @(posedge clk) begin
      if (reset) begin
        vld <= '0;
      end else if (ce) begin
        vld[0] <= din_valid;
        for (int i = 1; i < int'(D); i++) vld[i] <= vld[i-1];
      end
    end

    assign prod_d  = dly[D-1];
    assign valid_d = vld[D-1];
  end

  myproject_mul_rndsat #(
    .P          (P),
    .SHIFT      (SHIFT),
    .ROUND      (ROUND),
    .SAT        (SAT),
    .DOUT_W     (dout_WIDTH),
    .OUT_SIGNED (OUT_SIGNED)
  ) u_rndsat (
    .prod   (prod_d),
    .dout_c (rs_dout),
    .ovf_c  (rs_ovf)
  );

  // Output stage: result and flag only move on a valid slot, so bubbles leave dout untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      ovf        <= 1'b0;
    end else if (ce) begin
      dout_valid <= valid_d;
      if (valid_d) begin
        dout <= rs_dout;
        ovf  <= rs_ovf;
      end
    end
  end

  // Sticky overflow: a result counts once, when it advances out; a new set beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else begin
      ovf_sticky <= (ovf_sticky & ~clr_sticky) | (dout_valid & ovf & ce);
    end
  end

endmodule

// File: tb/tb_myproject_mul_pipe_rs.sv
// Self-checking bench: eight parameterisations share one stimulus stream and one scoreboard.
module tb_myproject_mul_pipe_rs;

  localparam int NC = 8;

  logic        clk = 1'b0;
  logic        reset, ce, din_valid, clr_sticky;
  logic [10:0] din0;
  logic [6:0]  din1;

  logic [17:0] d0, d1, d2, d5, d6;
  logic [11:0] d3, d4, d7;
  logic [17:0] dout_a [NC];
  logic        dv_a  [NC];
  logic        ovf_a [NC];
  logic        stk_a [NC];

  always #5 clk = ~clk;

  always_comb begin
    dout_a[0] = d0;  dout_a[1] = d1;  dout_a[2] = d2;  dout_a[3] = 18'(d3);
    dout_a[4] = 18'(d4);  dout_a[5] = d5;  dout_a[6] = d6;  dout_a[7] = 18'(d7);
  end

  myproject_mul_pipe_rs #(.ID(0)) u0 (.clk(clk), .reset(reset), .ce(ce), .din_valid(din_valid),
    .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d0), .dout_valid(dv_a[0]),
    .ovf(ovf_a[0]), .ovf_sticky(stk_a[0]));
  myproject_mul_pipe_rs #(.ID(1), .SHIFT(4), .ROUND(1)) u1 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d1),
    .dout_valid(dv_a[1]), .ovf(ovf_a[1]), .ovf_sticky(stk_a[1]));
  myproject_mul_pipe_rs #(.ID(2), .SHIFT(4), .ROUND(0)) u2 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d2),
    .dout_valid(dv_a[2]), .ovf(ovf_a[2]), .ovf_sticky(stk_a[2]));
  myproject_mul_pipe_rs #(.ID(3), .dout_WIDTH(12), .SAT(1)) u3 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d3),
    .dout_valid(dv_a[3]), .ovf(ovf_a[3]), .ovf_sticky(stk_a[3]));
  myproject_mul_pipe_rs #(.ID(4), .dout_WIDTH(12), .SAT(0)) u4 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d4),
    .dout_valid(dv_a[4]), .ovf(ovf_a[4]), .ovf_sticky(stk_a[4]));
  myproject_mul_pipe_rs #(.ID(5), .DIN0_SIGNED(0)) u5 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d5),
    .dout_valid(dv_a[5]), .ovf(ovf_a[5]), .ovf_sticky(stk_a[5]));
  myproject_mul_pipe_rs #(.ID(6), .NUM_STAGE(1)) u6 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d6),
    .dout_valid(dv_a[6]), .ovf(ovf_a[6]), .ovf_sticky(stk_a[6]));
  myproject_mul_pipe_rs #(.ID(7), .NUM_STAGE(3), .DIN0_SIGNED(0), .DIN1_SIGNED(0), .SHIFT(2),
    .ROUND(1), .dout_WIDTH(12), .SAT(1)) u7 (.clk(clk), .reset(reset), .ce(ce),
    .din_valid(din_valid), .din0(din0), .din1(din1), .clr_sticky(clr_sticky), .dout(d7),
    .dout_valid(dv_a[7]), .ovf(ovf_a[7]), .ovf_sticky(stk_a[7]));

  typedef struct {int ns; int w; int s0; int s1; int sh; int rnd; int sat;} cfg_t;

  function automatic cfg_t cfg(input int k);
    case (k)
      0:       return '{2, 18, 1, 1, 0, 0, 1};
      1:       return '{2, 18, 1, 1, 4, 1, 1};
      2:       return '{2, 18, 1, 1, 4, 0, 1};
      3:       return '{2, 12, 1, 1, 0, 0, 1};
      4:       return '{2, 12, 1, 1, 0, 0, 0};
      5:       return '{2, 18, 0, 1, 0, 0, 1};
      6:       return '{1, 18, 1, 1, 0, 0, 1};
      default: return '{3, 12, 0, 0, 2, 1, 1};
    endcase
  endfunction

  // Reference: plain integer arithmetic on the operand values.
  function automatic void model(input int k, input logic [10:0] a, input logic [6:0] b,
                                output logic [17:0] d, output logic o);
    cfg_t   c;
    longint av, bv, p, lo, hi, r;
    c  = cfg(k);
    av = longint'(a);
    bv = longint'(b);
    if (c.s0 != 0 && a[10]) av = av - 2048;
    if (c.s1 != 0 && b[6])  bv = bv - 128;
    p = av * bv;
    if (c.rnd != 0 && c.sh > 0) p = p + (longint'(1) << (c.sh - 1));
    p = p >>> c.sh;
    if (c.s0 != 0 || c.s1 != 0) begin
      lo = -(longint'(1) << (c.w - 1));
      hi = (longint'(1) << (c.w - 1)) - 1;
    end else begin
      lo = 0;
      hi = (longint'(1) << c.w) - 1;
    end
    o = (p < lo) || (p > hi);
    r = p;
    if (o && c.sat != 0) r = (p < lo) ? lo : hi;
    d = 18'(r & ((longint'(1) << c.w) - 1));
  endfunction

  typedef struct {int idx; logic [10:0] a; logic [6:0] b;} op_t;
  op_t         q[$];
  int          ce_cnt = 0;
  bit          mdl_on = 0;
  logic [17:0] e_dout [NC];
  bit          e_dv [NC], e_ovf [NC], e_stk [NC];
  int          errors = 0, checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: capture inputs, advance the reference, compare every instance.
  task automatic tick();
    logic r, c, v, cl;
    logic [10:0] a;
    logic [6:0]  b;
    bit found;
    r = reset; c = ce; v = din_valid; cl = clr_sticky; a = din0; b = din1;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      mdl_on = 1;
      for (int k = 0; k < NC; k++) begin
        e_dout[k] = '0; e_dv[k] = 0; e_ovf[k] = 0; e_stk[k] = 0;
      end
    end else if (mdl_on) begin
      for (int k = 0; k < NC; k++) e_stk[k] = (e_stk[k] && !cl) || (e_dv[k] && e_ovf[k] && c);
      if (c) begin
        if (v) q.push_back('{ce_cnt, a, b});
        ce_cnt++;
        for (int k = 0; k < NC; k++) begin
          found = 0;
          foreach (q[j]) begin
            if (q[j].idx == ce_cnt - cfg(k).ns) begin
              model(k, q[j].a, q[j].b, e_dout[k], e_ovf[k]);
              found = 1;
            end
          end
          e_dv[k] = found;
        end
        while (q.size() > 0 && q[0].idx < ce_cnt - 3) void'(q.pop_front());
      end
    end
    if (mdl_on) begin
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("dout_valid[%0d]", k), 32'(dv_a[k]), 32'(e_dv[k]));
        chk($sformatf("dout[%0d]", k), 32'(dout_a[k]), 32'(e_dout[k]));
        if (e_dv[k]) chk($sformatf("ovf[%0d]", k), 32'(ovf_a[k]), 32'(e_ovf[k]));
        chk($sformatf("ovf_sticky[%0d]", k), 32'(stk_a[k]), 32'(e_stk[k]));
      end
    end
  endtask

  task automatic idle(input int n);
    din_valid = 0; ce = 1; clr_sticky = 0; reset = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  typedef struct {int k; logic [10:0] a; logic [6:0] b; logic [17:0] d; logic o;} vec_t;
  vec_t tv [12];
  int   cnt, acc;
  logic [10:0] ext [4];

  initial begin
    tv[0]  = '{0, 11'h400, 7'h40, 18'd65536, 1'b0};
    tv[1]  = '{0, 11'd1023, 7'd63, 18'd64449, 1'b0};
    tv[2]  = '{1, 11'd25, 7'd3, 18'd5, 1'b0};
    tv[3]  = '{1, 11'h7E7, 7'd3, 18'h3FFFB, 1'b0};
    tv[4]  = '{2, 11'd25, 7'd3, 18'd4, 1'b0};
    tv[5]  = '{3, 11'h400, 7'h40, 18'h7FF, 1'b1};
    tv[6]  = '{3, 11'd1023, 7'h40, 18'h800, 1'b1};
    tv[7]  = '{4, 11'h400, 7'h40, 18'h0, 1'b1};
    tv[8]  = '{5, 11'd2047, 7'h40, 18'h20040, 1'b0};
    tv[9]  = '{6, 11'd3, 7'd5, 18'd15, 1'b0};
    tv[10] = '{7, 11'd2047, 7'd127, 18'hFFF, 1'b1};
    tv[11] = '{7, 11'd10, 7'd3, 18'd8, 1'b0};
    ext[0] = 11'h400; ext[1] = 11'h3FF; ext[2] = 11'h7FF; ext[3] = 11'h000;

    reset = 1; ce = 0; din_valid = 0; clr_sticky = 0; din0 = '0; din1 = '0;
    tick();
    tick();
    idle(3);

    // Directed vectors, each checked after its instance's latency.
    foreach (tv[i]) begin
      din0 = tv[i].a; din1 = tv[i].b; din_valid = 1; ce = 1;
      tick();
      din_valid = 0;
      for (int n = 1; n < cfg(tv[i].k).ns; n++) tick();
      chk($sformatf("vec%0d valid", i), 32'(dv_a[tv[i].k]), 32'd1);
      chk($sformatf("vec%0d dout", i), 32'(dout_a[tv[i].k]), 32'(tv[i].d));
      chk($sformatf("vec%0d ovf", i), 32'(ovf_a[tv[i].k]), 32'(tv[i].o));
    end
    idle(4);

    // Four inputs with ce low for three cycles in the middle.
    cnt = 0; acc = 0;
    for (int i = 0; i < 12; i++) begin
      ce = !(i >= 1 && i <= 3);
      din_valid = (acc < 4);
      din0 = 11'(100 + acc); din1 = 7'(acc + 1);
      tick();
      if (ce && din_valid) acc++;
      if (ce && dv_a[0]) cnt++;
    end
    chk("stall result count", 32'(cnt), 32'd4);

    // Reset with two operations in flight.
    idle(3);
    din_valid = 1; ce = 1; din0 = 11'd7; din1 = 7'd9;
    tick();
    din0 = 11'd5;
    tick();
    din_valid = 0; reset = 1;
    tick();
    reset = 0; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      for (int k = 0; k < NC; k++) if (dv_a[k]) cnt++;
    end
    chk("late result after reset", 32'(cnt), 32'd0);

    // Clear coincident with a fresh overflow keeps the sticky flag set.
    clr_sticky = 1;
    tick();
    clr_sticky = 0;
    chk("sticky cleared", 32'(stk_a[3]), 32'd0);
    din_valid = 1; din0 = 11'h400; din1 = 7'h40;
    tick();
    tick();
    din_valid = 0;
    tick();
    chk("sticky set", 32'(stk_a[3]), 32'd1);
    clr_sticky = 1;
    tick();
    chk("sticky clear vs set", 32'(stk_a[3]), 32'd1);
    tick();
    clr_sticky = 0;
    chk("sticky clear alone", 32'(stk_a[3]), 32'd0);

    // Randomised traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      din0       = ($urandom_range(0, 3) == 0) ? ext[$urandom_range(0, 3)] : 11'($urandom);
      din1       = ($urandom_range(0, 3) == 0) ? 7'(64 * $urandom_range(0, 1) + 63 * $urandom_range(0, 1)) : 7'($urandom);
      din_valid  = ($urandom_range(0, 9) < 7);
      ce         = ($urandom_range(0, 9) < 8);
      clr_sticky = ($urandom_range(0, 19) == 0);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
